// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared micro-op fields, classes, FSM states and opcode decode
package dispatch_pkg;

    localparam int UOP_W  = 24;
    localparam int OPC_HI = 23;
    localparam int OPC_LO = 16;
    localparam int DST_HI = 11;
    localparam int DST_LO = 8;
    localparam int S1_HI  = 7;
    localparam int S1_LO  = 4;
    localparam int S2_HI  = 3;
    localparam int S2_LO  = 0;

    // ALU ops, all write the register file
    localparam logic [7:0] UO_ADDB = 8'h01;
    localparam logic [7:0] UO_SUBB = 8'h02;
    localparam logic [7:0] UO_ANDB = 8'h03;
    localparam logic [7:0] UO_ORB  = 8'h04;
    // MEM ops, only the load writes the register file
    localparam logic [7:0] UO_LDB  = 8'h10;
    localparam logic [7:0] UO_STB  = 8'h11;
    // FCU ops, none write the register file
    localparam logic [7:0] UO_BEQ  = 8'h20;
    localparam logic [7:0] UO_BNE  = 8'h21;
    localparam logic [7:0] UO_JMP  = 8'h22;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ALU  = 2'd1,
        CLS_MEM  = 2'd2,
        CLS_FCU  = 2'd3
    } uop_class_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BRWAIT = 1'b1
    } disp_state_e;

    function automatic logic [7:0] uop_opcode(input logic [UOP_W-1:0] uop);
        return uop[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [3:0] uop_dst(input logic [UOP_W-1:0] uop);
        return uop[DST_HI:DST_LO];
    endfunction

    function automatic logic [3:0] uop_src1(input logic [UOP_W-1:0] uop);
        return uop[S1_HI:S1_LO];
    endfunction

    function automatic logic [3:0] uop_src2(input logic [UOP_W-1:0] uop);
        return uop[S2_HI:S2_LO];
    endfunction

    function automatic uop_class_e opcode_class(input logic [7:0] opc);
        case (opc)
            UO_ADDB, UO_SUBB, UO_ANDB, UO_ORB: return CLS_ALU;
            UO_LDB, UO_STB:                    return CLS_MEM;
            UO_BEQ, UO_BNE, UO_JMP:            return CLS_FCU;
            default:                           return CLS_NONE;
        endcase
    endfunction

    function automatic logic opcode_writes_rf(input logic [7:0] opc);
        case (opc)
            UO_ADDB, UO_SUBB, UO_ANDB, UO_ORB, UO_LDB: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uop_fifo.sv
// rtl/uop_fifo.sv - circular micro-op queue with synchronous clear
module uop_fifo #(
    parameter int QDEPTH = 4,
    parameter int WIDTH  = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [3:0]       count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [WIDTH-1:0] mem_q [QDEPTH];
    logic [WIDTH-1:0] mem_d [QDEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == 4'(QDEPTH));
    assign empty_o = (count_q == 4'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next pointers and occupancy; pointers wrap naturally since QDEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 4'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + {3'b000, do_push} - {3'b000, do_pop};
        end
    end

    // Control state is reset; the payload storage does not need to be
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uop_dispatch.sv
// rtl/uop_dispatch.sv - in-order micro-op dispatch with register scoreboard and branch wait
module uop_dispatch
    import dispatch_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int NREG   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [23:0]      in_uop_i,
    output logic             alu_valid_o,
    input  logic             alu_ready_i,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output logic             fcu_valid_o,
    input  logic             fcu_ready_i,
    output logic [23:0]      iss_uop_o,
    input  logic             wb_valid_i,
    input  logic [3:0]       wb_reg_i,
    input  logic             br_done_i,
    input  logic             br_miss_i,
    input  logic             flush_i,
    output logic [3:0]       count_o,
    output logic [NREG-1:0]  busy_o
);

    disp_state_e      state_q, state_d;
    logic [NREG-1:0]  busy_q, busy_d;
    logic             alive_q, alive_d;

    logic [UOP_W-1:0] head_uop;
    logic [3:0]       fifo_count;
    logic             fifo_full, fifo_empty;
    logic             push, pop, kill;

    uop_class_e       head_cls;
    logic [3:0]       head_dst, head_src1, head_src2;
    logic             head_wr, hazard, issue_ok, drop_none;
    logic             any_fire, fcu_fire, br_kill;

    uop_fifo #(
        .QDEPTH (QDEPTH),
        .WIDTH  (UOP_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (kill),
        .push_i  (push),
        .data_i  (in_uop_i),
        .pop_i   (pop),
        .data_o  (head_uop),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Decode the head op, evaluate hazards and drive the issue handshakes
    always_comb begin
        head_cls  = opcode_class(uop_opcode(head_uop));
        head_wr   = opcode_writes_rf(uop_opcode(head_uop));
        head_dst  = uop_dst(head_uop);
        head_src1 = uop_src1(head_uop);
        head_src2 = uop_src2(head_uop);
        hazard    = busy_q[head_src1] | busy_q[head_src2] | (head_wr & busy_q[head_dst]);
        issue_ok  = (state_q == ST_RUN) & ~fifo_empty & ~hazard;
        // Unclassified ops leave the queue without any unit seeing them
        drop_none = (state_q == ST_RUN) & ~fifo_empty & (head_cls == CLS_NONE);

        alu_valid_o = issue_ok & (head_cls == CLS_ALU);
        mem_valid_o = issue_ok & (head_cls == CLS_MEM);
        fcu_valid_o = issue_ok & (head_cls == CLS_FCU);

        fcu_fire = fcu_valid_o & fcu_ready_i;
        any_fire = (alu_valid_o & alu_ready_i) | (mem_valid_o & mem_ready_i) | fcu_fire;
        pop      = any_fire | drop_none;

        // A mispredict discards everything queued behind the branch, like a flush
        br_kill    = (state_q == ST_BRWAIT) & br_done_i & br_miss_i;
        kill       = flush_i | br_kill;
        in_ready_o = alive_q & ~fifo_full & ~kill;
        push       = in_valid_i & in_ready_o;
    end

    // Scoreboard: writeback clears, issue of a writer sets; set is applied last so it wins
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i) begin
            busy_d[wb_reg_i] = 1'b0;
        end
        if (any_fire && head_wr) begin
            busy_d[head_dst] = 1'b1;
        end
    end

    // Branch wait FSM next state; flush overrides any branch resolution
    always_comb begin
        state_d = state_q;
        alive_d = 1'b1;
        if (flush_i) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:    if (fcu_fire) state_d = ST_BRWAIT;
                ST_BRWAIT: if (br_done_i) state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // State registers; alive_q holds off enqueue until the first edge after reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            busy_q  <= '0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            alive_q <= alive_d;
        end
    end

    assign iss_uop_o = head_uop;
    assign count_o   = fifo_count;
    assign busy_o    = busy_q;

endmodule
